// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared-memory request/ready handshake between controller and memory
interface multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;
  modport master (output mem_read, mem_write, iord, input mem_ready);
  modport slave (input mem_read, mem_write, iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer with memory handshake, traps and retire counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  multicycle_ctrl_if.master    bus,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_src,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     instret
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3, S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_R_WB = 4'd7, S_BRANCH = 4'd8, S_TRAP = 4'd9
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] op_q, op_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic in_wait, tmo, retire;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end
  // Completion (mem_ready) wins over timeout in the same cycle.
  always_comb begin
    in_wait = state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR;
    tmo = in_wait && !bus.mem_ready && wait_q == WAIT_LAST;
    state_d = state_q;
    op_d = op_q;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : tmo ? S_TRAP : S_FETCH;
      S_DECODE: begin
        op_d = opcode;
        state_d = opcode == OP_R ? S_EXEC_R :
                  (opcode == OP_LD || opcode == OP_ST) ? S_MEM_ADDR :
                  opcode == OP_BR ? S_BRANCH : S_TRAP;
      end
      S_MEM_ADDR: state_d = op_q == OP_LD ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : tmo ? S_TRAP : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : tmo ? S_TRAP : S_MEM_WR;
      S_EXEC_R:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    cause_d = (state_d == S_TRAP && state_q != S_TRAP) ? (tmo ? 2'b10 : 2'b01) : cause_q;
    wait_d = (in_wait && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
    retire = state_d == S_FETCH && state_q != S_FETCH;
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end
  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_src = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
      end
      S_R_WB:     reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_src = 1'b1;
        pc_write = zero;
      end
      default: ;
    endcase
  end
  assign trap = state_q == S_TRAP;
  assign trap_cause = cause_q;
  assign state = state_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenario tests for the multi-cycle controller
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_ILL = 7'b0010011;
  logic clk = 1'b0;
  logic reset;
  logic [6:0] opcode;
  logic zero;
  logic pc_write, ir_write, reg_write, mem_to_reg, alu_src_a, pc_src, trap;
  logic [1:0] alu_src_b, alu_op, trap_cause;
  logic [3:0] state;
  logic [31:0] instret;
  int tests = 0;
  int fails = 0;
  multicycle_ctrl_if mif();
  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .bus(mif.master),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .trap(trap), .trap_cause(trap_cause), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if ({state, trap, trap_cause, mif.mem_read, mif.iord} !== {4'd0, 1'b0, 2'b00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: state=%0d trap=%b cause=%b mem_read=%b iord=%b, want 0 0 00 1 0",
               state, trap, trap_cause, mif.mem_read, mif.iord);
    end
    tests++;
    if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %0d want 0", instret); end
  endtask
  task automatic test_zero_wait();
    logic [3:0] exp_st [16] = '{0,1,6,7, 0,1,2,3,4, 0,1,2,5, 0,1,8};
    logic [6:0] ops [16] = '{OP_R,OP_R,OP_R,OP_R, OP_LD,OP_LD,OP_LD,OP_LD,OP_LD,
                             OP_ST,OP_ST,OP_ST,OP_ST, OP_BR,OP_BR,OP_BR};
    mif.mem_ready = 1'b1;
    zero = 1'b1;
    for (int i = 0; i < 16; i++) begin
      opcode = ops[i];
      #1;
      tests++;
      if (state !== exp_st[i]) begin
        fails++;
        $display("FAIL zero_wait_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 15) begin
        tests++;
        if (pc_write !== 1'b1) begin fails++; $display("FAIL branch_taken_pc_write: got %b want 1", pc_write); end
      end
      cyc();
    end
    tests++;
    if (state !== 4'd0 || instret !== 32'd4) begin
      fails++;
      $display("FAIL zero_wait_retire: state=%0d instret=%0d want 0 4", state, instret);
    end
  endtask
  task automatic test_branch_not_taken();
    mif.mem_ready = 1'b1;
    zero = 1'b0;
    opcode = OP_BR;
    cyc();
    cyc();
    tests++;
    if ({state, pc_write, pc_src, alu_op} !== {4'd8, 1'b0, 1'b1, 2'b01}) begin
      fails++;
      $display("FAIL branch_nt: state=%0d pc_write=%b pc_src=%b alu_op=%b want 8 0 1 01",
               state, pc_write, pc_src, alu_op);
    end
    cyc();
    tests++;
    if (state !== 4'd0 || instret !== 32'd5) begin
      fails++;
      $display("FAIL branch_nt_retire: state=%0d instret=%0d want 0 5", state, instret);
    end
  endtask
  task automatic test_mem_wait();
    mif.mem_ready = 1'b1;
    opcode = OP_LD;
    cyc();
    cyc();
    cyc();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mif.mem_ready = 1'b1;
      #1;
      tests++;
      if ({state, mif.mem_read, mif.iord, mif.mem_write} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL mem_wait_hold[%0d]: state=%0d mem_read=%b iord=%b want 3 1 1", i, state, mif.mem_read, mif.iord);
      end
      cyc();
    end
    tests++;
    if (state !== 4'd4 || trap !== 1'b0 || reg_write !== 1'b1 || mem_to_reg !== 1'b1) begin
      fails++;
      $display("FAIL mem_wait_wb: state=%0d trap=%b reg_write=%b mem_to_reg=%b want 4 0 1 1",
               state, trap, reg_write, mem_to_reg);
    end
    cyc();
    tests++;
    if (instret !== 32'd6) begin fails++; $display("FAIL mem_wait_retire: got %0d want 6", instret); end
  endtask
  task automatic test_timeout_boundary();
    opcode = OP_R;
    mif.mem_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    mif.mem_ready = 1'b1;
    #1;
    tests++;
    if (state !== 4'd0 || ir_write !== 1'b1) begin
      fails++;
      $display("FAIL timeout_edge_fetch: state=%0d ir_write=%b want 0 1", state, ir_write);
    end
    cyc();
    tests++;
    if (state !== 4'd1 || trap !== 1'b0) begin
      fails++;
      $display("FAIL timeout_edge_decode: state=%0d trap=%b want 1 0", state, trap);
    end
    cyc();
    cyc();
    cyc();
    tests++;
    if (state !== 4'd0 || instret !== 32'd7) begin
      fails++;
      $display("FAIL timeout_edge_retire: state=%0d instret=%0d want 0 7", state, instret);
    end
  endtask
  task automatic test_timeout();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    tests++;
    if ({state, trap, trap_cause, mif.mem_read} !== {4'd9, 1'b1, 2'b10, 1'b0}) begin
      fails++;
      $display("FAIL timeout_trap: state=%0d trap=%b cause=%b mem_read=%b want 9 1 10 0",
               state, trap, trap_cause, mif.mem_read);
    end
    tests++;
    if (instret !== 32'd7) begin fails++; $display("FAIL timeout_instret: got %0d want 7", instret); end
  endtask
  task automatic test_illegal();
    logic left;
    do_reset();
    mif.mem_ready = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 4; i++) cyc();
    opcode = OP_ILL;
    cyc();
    cyc();
    tests++;
    if ({state, trap, trap_cause} !== {4'd9, 1'b1, 2'b01}) begin
      fails++;
      $display("FAIL illegal_trap: state=%0d trap=%b cause=%b want 9 1 01", state, trap, trap_cause);
    end
    tests++;
    if ({pc_write, ir_write, mif.mem_read, mif.mem_write, reg_write} !== 5'b0) begin
      fails++;
      $display("FAIL illegal_enables: pcw=%b irw=%b mr=%b mw=%b rw=%b want all 0",
               pc_write, ir_write, mif.mem_read, mif.mem_write, reg_write);
    end
    tests++;
    if (instret !== 32'd1) begin fails++; $display("FAIL illegal_instret: got %0d want 1", instret); end
    left = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mif.mem_ready = i[0];
      opcode = OP_R;
      cyc();
      if (state !== 4'd9 || trap_cause !== 2'b01) left = 1'b1;
    end
    tests++;
    if (left !== 1'b0) begin fails++; $display("FAIL illegal_stuck: left TRAP or cause changed, got state=%0d", state); end
    do_reset();
    tests++;
    if (state !== 4'd0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
      fails++;
      $display("FAIL illegal_reset_exit: state=%0d trap=%b cause=%b want 0 0 00", state, trap, trap_cause);
    end
  endtask
  task automatic test_reset_mid_wait();
    mif.mem_ready = 1'b1;
    opcode = OP_LD;
    cyc();
    cyc();
    cyc();
    mif.mem_ready = 1'b0;
    cyc();
    tests++;
    if (state !== 4'd3) begin fails++; $display("FAIL mid_wait_setup: state=%0d want 3", state); end
    do_reset();
    tests++;
    if ({state, trap, mif.mem_read, mif.iord, mif.mem_write} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0} || instret !== 32'd0) begin
      fails++;
      $display("FAIL mid_wait_reset: state=%0d trap=%b mr=%b iord=%b mw=%b instret=%0d want 0 0 1 0 0 0",
               state, trap, mif.mem_read, mif.iord, mif.mem_write, instret);
    end
  endtask
  initial begin
    reset = 1'b1;
    opcode = 7'd0;
    zero = 1'b0;
    mif.mem_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_branch_not_taken();
    test_mem_wait();
    test_timeout_boundary();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
